// File: rtl/vec_alu_pkg.sv
// Shared types and defaults for the lane-parallel vector ALU.
// Optional divider is enabled by defining VEC_ALU_DIV_EN.
package vec_alu_pkg;

  localparam int DEF_WIDTH = 20;
  localparam int DEF_LANES = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MOV = 3'b010,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100
  } vec_op_e;

endpackage

// File: rtl/vec_alu_lane.sv
// Combinational single-element ALU; divide exists only with VEC_ALU_DIV_EN.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

`ifdef VEC_ALU_DIV_EN
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;

  // Unrolled restoring divider: one compare/subtract row per quotient bit.
  always_comb begin
    quo = '0;
    rem = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      rem = {rem[WIDTH-1:0], a[k]};
      if (rem >= {1'b0, b}) begin
        rem    = rem - {1'b0, b};
        quo[k] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MOV: y = a;
      OP_MUL: y = a * b;
`ifdef VEC_ALU_DIV_EN
      OP_DIV: y = (b == '0) ? '1 : quo;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu.sv
// Lane-parallel vector ALU with a single registered output stage.
// Define VEC_ALU_DIV_EN to build the per-lane divider for opcode 100.
module vec_alu
  import vec_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LANES-1:0][WIDTH-1:0] A,
  input  logic [LANES-1:0][WIDTH-1:0] B,
  input  logic [2:0]                  Operation,
  output logic [LANES-1:0][WIDTH-1:0] Result
);

  logic [LANES-1:0][WIDTH-1:0] lane_res;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_alu_lane #(.WIDTH(WIDTH)) u_lane (
      .a  (A[i]),
      .b  (B[i]),
      .op (Operation),
      .y  (lane_res[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) Result <= '0;
    else       Result <= lane_res;
  end

endmodule

// File: tb/tb_vec_alu.sv
// Scoreboard bench for vec_alu: expectations queued at drive time, checked one edge later.
module tb_vec_alu;
  localparam int W = 20;
  localparam int L = 8;
  typedef logic [L-1:0][W-1:0] vec_t;

  logic       clk = 1'b0;
  logic       reset;
  vec_t       A, B, Result;
  logic [2:0] Operation;

  int   errs = 0;
  int   chks = 0;
  vec_t sb_q[$];

  vec_alu #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .Operation (Operation),
    .Result    (Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t model(input vec_t a, input vec_t b, input logic [2:0] op);
    vec_t r;
    longint unsigned x, y, m;
    m = (64'd1 << W) - 1;
    for (int i = 0; i < L; i++) begin
      x = 64'(a[i]);
      y = 64'(b[i]);
      case (op)
        3'd0: r[i] = W'((x + y) & m);
        3'd1: r[i] = W'((x - y) & m);
        3'd2: r[i] = W'(x);
        3'd3: r[i] = W'((x * y) & m);
`ifdef VEC_ALU_DIV_EN
        3'd4: r[i] = (y == 0) ? W'(m) : W'(x / y);
`endif
        default: r[i] = '0;
      endcase
    end
    return r;
  endfunction

  task automatic step(input string tag, input vec_t a, input vec_t b,
                      input logic [2:0] op, input logic rst);
    A = a; B = b; Operation = op; reset = rst;
    sb_q.push_back(rst ? vec_t'('0) : model(a, b, op));
    @(posedge clk);
    #1;
    chk(tag, Result, sb_q.pop_front());
  endtask

  initial begin
    vec_t a, b, held;
    A = '0; B = '0; Operation = 3'd0; reset = 1'b1;
    @(negedge clk);

    step("reset", {L{20'h5A5A5}}, {L{20'h12345}}, 3'd3, 1'b1);

    step("add", {20'd200,20'd254,20'd251,20'd200,20'd5,20'd10,20'd100,20'd15},
                {20'd100,20'd1,20'd1,20'd45,20'd25,20'd1,20'd2,20'd10}, 3'd0, 1'b0);
    chk("add_const", Result, {20'd300,20'd255,20'd252,20'd245,20'd30,20'd11,20'd102,20'd25});
    step("add_wrap", {L{20'hFFFFF}}, {L{20'd1}}, 3'd0, 1'b0);

    step("sub", {20'd100,20'd255,20'd251,20'd200,20'd25,20'd10,20'd100,20'd15},
                {20'd100,20'd55,20'd1,20'd45,20'd5,20'd1,20'd2,20'd10}, 3'd1, 1'b0);
    chk("sub_const", Result, {20'd0,20'd200,20'd250,20'd155,20'd20,20'd9,20'd98,20'd5});
    step("sub_wrap", {L{20'd0}}, {L{20'd1}}, 3'd1, 1'b0);
    chk("sub_wrap_const", Result, {L{20'hFFFFF}});

    step("mov", {20'd100,20'd255,20'd251,20'd200,20'd25,20'd10,20'd100,20'd15},
                {L{20'hABCDE}}, 3'd2, 1'b0);

    step("mul", {20'd2,20'd6,20'd10,20'd15,20'd4,20'd8,20'd25,20'd50},
                {20'd2,20'd2,20'd20,20'd2,20'd5,20'd5,20'd2,20'd2}, 3'd3, 1'b0);
    chk("mul_const", Result, {20'd4,20'd12,20'd200,20'd30,20'd20,20'd40,20'd50,20'd100});
    step("mul_wrap", {L{20'd1024}}, {L{20'd1024}}, 3'd3, 1'b0);

    step("div", {20'd2,20'd6,20'd10,20'd15,20'd200,20'd8,20'd25,20'd50},
                {20'd2,20'd2,20'd2,20'd2,20'd100,20'd4,20'd5,20'd2}, 3'd4, 1'b0);
`ifdef VEC_ALU_DIV_EN
    chk("div_const", Result, {20'd1,20'd3,20'd5,20'd7,20'd2,20'd2,20'd5,20'd25});
`else
    chk("div_off_const", Result, '0);
`endif
    step("div_zero", {20'd7,20'd9,20'd0,20'hFFFFF,20'd1,20'd2,20'd3,20'd4},
                     {20'd0,20'd3,20'd0,20'd0,20'd1,20'd0,20'd3,20'd5}, 3'd4, 1'b0);

    for (int op = 5; op < 8; op++)
      step("reserved", {L{20'h13579}}, {L{20'h00042}}, 3'(op), 1'b0);

    // Result must hold while inputs move between edges.
    step("pre_hold", {L{20'd9}}, {L{20'd4}}, 3'd0, 1'b0);
    held = Result;
    A = {L{20'd77}}; Operation = 3'd3;
    #3;
    chk("hold", Result, held);

    step("pre_rst", {L{20'd1}}, {L{20'd2}}, 3'd0, 1'b0);
    step("mid_rst", {L{20'd3}}, {L{20'd4}}, 3'd0, 1'b1);
    step("post_rst", {L{20'd3}}, {L{20'd4}}, 3'd0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < L; i++) begin
        a[i] = W'($urandom);
        b[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1)) : W'($urandom);
      end
      step("rand", a, b, 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
